// File: rtl/i2s_transmitter.sv
// i2s_transmitter: 24-bit mono sample -> I2S (bclk/lrclk/sdata), valid/ready into one-entry buffer; pulses frame_start/underrun
module i2s_transmitter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [5:0] bit_cnt, b;
  logic [4:0] s, idx;
  logic [23:0] shreg, hold;
  logic full, wrap, fall, load;
  always_comb begin
    wrap = div_cnt == DW'(CLK_DIV - 1);
    fall = wrap && bclk;
    b = bit_cnt + 6'd1;
    s = b[4:0];
    idx = 5'd24 - s;
    load = fall && b == 6'd0;
  end
  assign in_ready = !full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= 6'd63;
      bclk <= 1'b0;
      lrclk <= 1'b1;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      shreg <= '0;
      hold <= '0;
      full <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      frame_start <= load;
      underrun <= load && !full;
      if (wrap) bclk <= !bclk;
      if (fall) begin
        bit_cnt <= b;
        lrclk <= b[5];
        sdata <= (s != 5'd0 && s <= 5'd24) ? shreg[idx] : 1'b0;
      end
      if (load && full) begin
        shreg <= hold;
        full <= 1'b0;
      end else if (in_valid && !full) begin
        hold <= in;
        full <= 1'b1;
      end
    end
endmodule
